// File: rtl/bonus_ship_pkg.sv
// Shared types and constants for the bonus (mystery) ship scheduler.
// The shot-indexed score table is used only when BONUS_SHOT_TABLE_EN is defined.
package bonus_ship_pkg;

  localparam int unsigned SCORE_W = 9;
  localparam int unsigned LIMIT_W = 10;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned SHOT_W  = 4;
  localparam int unsigned SHOT_N  = 15;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned Y_W     = 11;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_COOLDOWN  = 3'd1,
    S_WAIT_COND = 3'd2,
    S_LAUNCH    = 3'd3,
    S_FLYING    = 3'd4,
    S_SHOW      = 3'd5
  } bship_state_e;

  localparam logic [SCORE_W-1:0] SCORE_TABLE [SHOT_N] = '{
    9'd100, 9'd50,  9'd50,  9'd100, 9'd150,
    9'd100, 9'd100, 9'd50,  9'd300, 9'd100,
    9'd100, 9'd100, 9'd50,  9'd150, 9'd100
  };

  // Table lookup that stays in range even for the unused index 15.
  function automatic logic [SCORE_W-1:0] shot_score(input logic [SHOT_W-1:0] idx);
    shot_score = SCORE_TABLE[0];
    for (int unsigned i = 0; i < SHOT_N; i++) begin
      if (idx == SHOT_W'(i)) shot_score = SCORE_TABLE[i];
    end
  endfunction

endpackage

// File: rtl/bonus_frame_timer.sv
// Loadable frame down-counter shared by cooldown, alive timeout and score display.
// expire_c flags the startOfFrame that takes the count from 1 to 0.
module bonus_frame_timer
  import bonus_ship_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  input  logic         startOfFrame,
  output logic         done,
  output logic         expire_c
);

  logic [W-1:0] count_q, count_d;
  logic         done_q, done_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = loadValue;
    end else if (startOfFrame && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
    done_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done     = done_q;
  assign expire_c = startOfFrame && (count_q == W'(1));

endmodule

// File: rtl/bonus_ship_scheduler.sv
// Bonus ship sequencer: cooldown, launch gating, travel limit, hit award and score display.
// Build option BONUS_SHOT_TABLE_EN selects the shot-count score table instead of a fixed 100.
module bonus_ship_scheduler
  import bonus_ship_pkg::*;
#(
  parameter int unsigned COOLDOWN_FRAMES      = 600,
  parameter int unsigned HIT_SHOW_FRAMES      = 30,
  parameter int          MIN_ALIEN_Y          = 100,
  parameter int unsigned MIN_LIMIT_X          = 450,
  parameter int unsigned MAX_LIMIT_X          = 600,
  parameter int unsigned ALIVE_TIMEOUT_FRAMES = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic                  playGame,
  input  logic signed [Y_W-1:0] alienMatrixYPosition,
  input  logic [LIMIT_W-1:0]    randX,
  input  logic                  playerFire,
  input  logic                  bonusFireCollision,
  input  logic                  shipAlive,
  output logic                  launch,
  output logic [LIMIT_W-1:0]    limitX,
  output logic                  scoreValid,
  output logic [SCORE_W-1:0]    scoreValue,
  output logic                  showScore,
  output logic [STATE_W-1:0]    state
);

  localparam logic signed [Y_W-1:0] MIN_Y_S   = Y_W'(MIN_ALIEN_Y);
  localparam logic [LIMIT_W-1:0]    MIN_X     = LIMIT_W'(MIN_LIMIT_X);
  localparam logic [LIMIT_W-1:0]    MAX_X     = LIMIT_W'(MAX_LIMIT_X);
  localparam logic [CNT_W-1:0]      CD_LOAD   = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0]      SHOW_LOAD = CNT_W'(HIT_SHOW_FRAMES);
  localparam logic [CNT_W-1:0]      TO_LOAD   = CNT_W'(ALIVE_TIMEOUT_FRAMES);

  bship_state_e         state_q, state_d;
  logic [LIMIT_W-1:0]   limit_q, limit_d;
  logic                 seen_q, seen_d;
  logic                 launch_q, launch_d;
  logic                 valid_q, valid_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 show_q, show_d;

  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_value;
  logic                 tmr_done;
  logic                 tmr_expire_c;
  logic                 tmr_tick_c;
  logic                 launch_ok_c;
  logic [SCORE_W-1:0]   award_c;

  bonus_frame_timer #(.W(CNT_W)) u_timer (
    .clk          (clk),
    .resetN       (resetN),
    .load         (tmr_load),
    .loadValue    (tmr_value),
    .startOfFrame (startOfFrame),
    .done         (tmr_done),
    .expire_c     (tmr_expire_c)
  );

  assign tmr_tick_c  = tmr_expire_c || tmr_done;
  assign launch_ok_c = (alienMatrixYPosition > MIN_Y_S) &&
                       (randX >= MIN_X) && (randX <= MAX_X) &&
                       (randX != limit_q);

`ifdef BONUS_SHOT_TABLE_EN
  logic [SHOT_W-1:0] shot_q, shot_d;

  // Shots fired this game; a shot in the hit cycle only affects the next award.
  always_comb begin
    shot_d = shot_q;
    if (!playGame) begin
      shot_d = '0;
    end else if ((state_q != S_IDLE) && playerFire) begin
      shot_d = (shot_q == SHOT_W'(SHOT_N - 1)) ? '0 : shot_q + SHOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) shot_q <= '0;
    else         shot_q <= shot_d;
  end

  assign award_c = shot_score(shot_q);
`else
  logic unused_fire;
  assign unused_fire = playerFire;
  assign award_c     = SCORE_W'(100);
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    seen_d    = seen_q;
    valid_d   = 1'b0;
    score_d   = score_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    if (!playGame) begin
      state_d  = S_IDLE;
      seen_d   = 1'b0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_COOLDOWN;
          tmr_load  = 1'b1;
          tmr_value = CD_LOAD;
        end
        S_COOLDOWN: begin
          if (tmr_tick_c) state_d = S_WAIT_COND;
        end
        S_WAIT_COND: begin
          if (launch_ok_c) begin
            limit_d = randX;
            state_d = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          seen_d    = 1'b0;
          tmr_load  = 1'b1;
          tmr_value = TO_LOAD;
          state_d   = S_FLYING;
        end
        S_FLYING: begin
          if (shipAlive) seen_d = 1'b1;
          if (bonusFireCollision) begin
            valid_d   = 1'b1;
            score_d   = award_c;
            tmr_load  = 1'b1;
            tmr_value = SHOW_LOAD;
            state_d   = S_SHOW;
          end else if (seen_q && !shipAlive) begin
            tmr_load  = 1'b1;
            tmr_value = CD_LOAD;
            state_d   = S_COOLDOWN;
          end else if (!seen_q && !shipAlive && tmr_tick_c) begin
            tmr_load  = 1'b1;
            tmr_value = CD_LOAD;
            state_d   = S_COOLDOWN;
          end
        end
        S_SHOW: begin
          if (tmr_tick_c) begin
            tmr_load  = 1'b1;
            tmr_value = CD_LOAD;
            state_d   = S_COOLDOWN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    launch_d = (state_d == S_LAUNCH);
    show_d   = (state_d == S_SHOW);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= S_IDLE;
      limit_q  <= MIN_X;
      seen_q   <= 1'b0;
      launch_q <= 1'b0;
      valid_q  <= 1'b0;
      score_q  <= '0;
      show_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      limit_q  <= limit_d;
      seen_q   <= seen_d;
      launch_q <= launch_d;
      valid_q  <= valid_d;
      score_q  <= score_d;
      show_q   <= show_d;
    end
  end

  assign launch     = launch_q;
  assign limitX     = limit_q;
  assign scoreValid = valid_q;
  assign scoreValue = score_q;
  assign showScore  = show_q;
  assign state      = state_q;

endmodule

// File: tb/tb_bonus_ship_scheduler.sv
// Bench for bonus_ship_scheduler: directed scenarios plus random traffic against a frame-level model.
module tb_bonus_ship_scheduler;

  localparam int CD  = 4;
  localparam int HS  = 3;
  localparam int TO  = 4;

  localparam int M_IDLE = 0, M_COOL = 1, M_WAIT = 2, M_LAUNCH = 3, M_FLY = 4, M_SHOW = 5;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               playGame;
  logic signed [10:0] alienY;
  logic [9:0]         randX;
  logic               playerFire;
  logic               coll;
  logic               shipAlive;
  logic               launch;
  logic [9:0]         limitX;
  logic               scoreValid;
  logic [8:0]         scoreValue;
  logic               showScore;
  logic [2:0]         state;

  bonus_ship_scheduler #(
    .COOLDOWN_FRAMES      (CD),
    .HIT_SHOW_FRAMES      (HS),
    .MIN_ALIEN_Y          (100),
    .MIN_LIMIT_X          (450),
    .MAX_LIMIT_X          (600),
    .ALIVE_TIMEOUT_FRAMES (TO)
  ) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .playGame             (playGame),
    .alienMatrixYPosition (alienY),
    .randX                (randX),
    .playerFire           (playerFire),
    .bonusFireCollision   (coll),
    .shipAlive            (shipAlive),
    .launch               (launch),
    .limitX               (limitX),
    .scoreValid           (scoreValid),
    .scoreValue           (scoreValue),
    .showScore            (showScore),
    .state                (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int score_tbl [15] = '{100, 50, 50, 100, 150, 100, 100, 50, 300, 100, 100, 100, 50, 150, 100};

  int m_mode, m_frames, m_shots, m_limit, m_score;
  bit m_seen, m_launch, m_valid, m_show;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int award();
`ifdef BONUS_SHOT_TABLE_EN
    return score_tbl[m_shots];
`else
    return 100;
`endif
  endfunction

  function automatic int hit_score(input int shots);
`ifdef BONUS_SHOT_TABLE_EN
    return score_tbl[shots % 15];
`else
    return 100 + 0 * shots;
`endif
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_frames = 0; m_shots = 0; m_limit = 450; m_score = 0;
    m_seen = 0; m_launch = 0; m_valid = 0; m_show = 0;
  endtask

  // Frame-level behaviour: one call per clock edge using the inputs presented for it.
  task automatic model_step();
    int  prev_mode;
    bit  was_seen;
    prev_mode = m_mode;
    was_seen  = m_seen;
    m_valid   = 0;
    if (!playGame) begin
      m_mode = M_IDLE; m_frames = 0; m_seen = 0; m_shots = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin m_mode = M_COOL; m_frames = CD; end
        M_COOL: begin
          if (startOfFrame && m_frames > 0) m_frames--;
          if (m_frames == 0) m_mode = M_WAIT;
        end
        M_WAIT: begin
          if (int'(alienY) > 100 && int'(randX) >= 450 && int'(randX) <= 600 &&
              int'(randX) != m_limit) begin
            m_limit = int'(randX);
            m_mode  = M_LAUNCH;
          end
        end
        M_LAUNCH: begin m_seen = 0; m_frames = TO; m_mode = M_FLY; end
        M_FLY: begin
          if (shipAlive) m_seen = 1;
          if (coll) begin
            m_valid = 1; m_score = award(); m_frames = HS; m_mode = M_SHOW;
          end else if (was_seen && !shipAlive) begin
            m_mode = M_COOL; m_frames = CD;
          end else if (!m_seen) begin
            if (startOfFrame && m_frames > 0) m_frames--;
            if (m_frames == 0) begin m_mode = M_COOL; m_frames = CD; end
          end
        end
        M_SHOW: begin
          if (startOfFrame && m_frames > 0) m_frames--;
          if (m_frames == 0) begin m_mode = M_COOL; m_frames = CD; end
        end
        default: m_mode = M_IDLE;
      endcase
      if (prev_mode != M_IDLE && playerFire) m_shots = (m_shots + 1) % 15;
    end
    m_launch = (m_mode == M_LAUNCH);
    m_show   = (m_mode == M_SHOW);
  endtask

  task automatic compare_all();
    check("state",      32'(state),      32'(m_mode));
    check("launch",     32'(launch),     32'(m_launch));
    check("limitX",     32'(limitX),     32'(m_limit));
    check("scoreValid", 32'(scoreValid), 32'(m_valid));
    check("scoreValue", 32'(scoreValue), 32'(m_score));
    check("showScore",  32'(showScore),  32'(m_show));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic frame();
    startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0; tick();
  endtask

  task automatic fire_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      playerFire = 1'b1; tick();
      playerFire = 1'b0; tick();
    end
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; playGame = 1'b0; alienY = 11'sd120;
    randX = 10'd500; playerFire = 1'b0; coll = 1'b0; shipAlive = 1'b0;
    model_reset();
    #12;
    check("rst_state",  32'(state),      32'd0);
    check("rst_launch", 32'(launch),     32'd0);
    check("rst_limitX", 32'(limitX),     32'd450);
    check("rst_valid",  32'(scoreValid), 32'd0);
    check("rst_score",  32'(scoreValue), 32'd0);
    check("rst_show",   32'(showScore),  32'd0);
    resetN = 1'b1;
    @(posedge clk); #1;

    // First flight: cooldown exactness, launch, 8 shots then hit.
    playGame = 1'b1; tick();
    for (int i = 0; i < 3; i++) frame();
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    check("wait_after_cd", 32'(state), 32'd2);
    tick();
    check("launch_pulse", 32'(launch), 32'd1);
    check("launch_limit", 32'(limitX), 32'd500);
    tick();
    check("launch_one_cycle", 32'(launch), 32'd0);
    shipAlive = 1'b1; tick();
    fire_pulses(8);
    coll = 1'b1; tick(); coll = 1'b0; shipAlive = 1'b0;
    check("hit8_valid", 32'(scoreValid), 32'd1);
    check("hit8_score", 32'(scoreValue), 32'(hit_score(8)));
    check("hit8_show",  32'(showScore),  32'd1);
    for (int i = 0; i < HS - 1; i++) frame();
    check("show_hold", 32'(showScore), 32'd1);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    check("show_end_state", 32'(state), 32'd1);
    check("show_end_show",  32'(showScore), 32'd0);

    // Launch-condition boundaries.
    alienY = 11'sd100; randX = 10'd520;
    for (int i = 0; i < CD; i++) frame();
    check("y100_block", 32'(state), 32'd2);
    alienY = 11'sd120; randX = 10'd449; tick();
    check("x449_block", 32'(launch), 32'd0);
    randX = 10'd601; tick();
    check("x601_block", 32'(launch), 32'd0);
    randX = 10'd500; tick();
    check("prev_block", 32'(state), 32'd2);
    randX = 10'd450; tick();
    check("x450_launch", 32'(launch), 32'd1);
    check("x450_limit",  32'(limitX), 32'd450);
    tick();

    // Escape without a hit.
    shipAlive = 1'b1; tick(); tick();
    shipAlive = 1'b0; tick();
    check("escape_state", 32'(state), 32'd1);
    check("escape_novalid", 32'(scoreValid), 32'd0);

    // Hit coinciding with shipAlive falling.
    for (int i = 0; i < CD; i++) frame();
    randX = 10'd600; tick();
    check("x600_limit", 32'(limitX), 32'd600);
    tick();
    shipAlive = 1'b1; tick();
    shipAlive = 1'b0; coll = 1'b1; tick(); coll = 1'b0;
    check("fall_hit_valid", 32'(scoreValid), 32'd1);

    // Drop playGame during SHOW.
    playGame = 1'b0; tick();
    check("drop_state", 32'(state), 32'd0);
    check("drop_show",  32'(showScore), 32'd0);
    check("drop_limit", 32'(limitX), 32'd600);
    playGame = 1'b1; tick();

    // 16 shots wrap the table index to 1.
    randX = 10'd510;
    for (int i = 0; i < CD; i++) frame();
    tick();
    shipAlive = 1'b1; tick();
    fire_pulses(16);
    coll = 1'b1; tick(); coll = 1'b0; shipAlive = 1'b0;
    check("wrap_score", 32'(scoreValue), 32'(hit_score(16)));
    for (int i = 0; i < HS; i++) frame();

    // Mover never reports alive: timeout.
    for (int i = 0; i < CD; i++) frame();
    randX = 10'd530; tick(); tick();
    for (int i = 0; i < TO - 1; i++) frame();
    check("timeout_hold", 32'(state), 32'd4);
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    check("timeout_state", 32'(state), 32'd1);

    // Asynchronous reset in flight.
    for (int i = 0; i < CD; i++) frame();
    randX = 10'd540; tick(); tick();
    shipAlive = 1'b1; tick();
    resetN = 1'b0;
    #1;
    model_reset();
    check("arst_state", 32'(state),      32'd0);
    check("arst_limit", 32'(limitX),     32'd450);
    check("arst_score", 32'(scoreValue), 32'd0);
    check("arst_show",  32'(showScore),  32'd0);
    #1;
    resetN = 1'b1; shipAlive = 1'b0;
    @(posedge clk); #1;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      startOfFrame = ($urandom_range(2, 0) == 0);
      playerFire   = ($urandom_range(3, 0) == 0);
      coll         = ($urandom_range(24, 0) == 0);
      if ($urandom_range(9, 0) == 0) shipAlive = ~shipAlive;
      if (playGame) playGame = ($urandom_range(299, 0) != 0);
      else          playGame = ($urandom_range(2, 0) == 0);
      alienY = 11'($urandom_range(130, 95));
      if ($urandom_range(7, 0) == 0) randX = 10'(m_limit);
      else                           randX = 10'($urandom_range(610, 440));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bonus_ship_scheduler.md
# bonus_ship_scheduler

Sequencer for the bonus (mystery) ship. Owns the launch decision: spawn cooldown, launch conditions and the per-flight travel limit. Also owns the hit outcome: score award and score-display window. Sits between game control, the random source and the bonus-ship mover/collision logic; drives the mover's launch and travel limit and reports awarded points to the score unit.

## Interface
- COOLDOWN_FRAMES, 600, frames between flights (20 s at 30 Hz); legal 1..1023
- HIT_SHOW_FRAMES, 30, frames the awarded score is displayed after a hit; legal 1..1023
- MIN_ALIEN_Y, 100, alien matrix Y must be strictly greater than this to launch
- MIN_LIMIT_X, 450, lowest accepted randX for a travel limit
- MAX_LIMIT_X, 600, highest accepted randX for a travel limit
- ALIVE_TIMEOUT_FRAMES, 4, frames to wait for mover's shipAlive after launch
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- playGame  in  1  game running; low forces IDLE (synchronous)
- alienMatrixYPosition  in  11 signed  current alien matrix top Y
- randX  in  10  free-running random value
- playerFire  in  1  one-cycle pulse per player shot fired
- bonusFireCollision  in  1  player shot hit the bonus ship
- shipAlive  in  1  mover reports ship on screen
- launch  out  1  one-cycle pulse: mover starts a flight
- limitX  out  10  travel limit for current flight, stable from launch until next launch
- scoreValid  out  1  one-cycle pulse, scoreValue valid
- scoreValue  out  9  points awarded (50/100/150/300)
- showScore  out  1  high during score-display window
- state  out  3  current FSM state (debug)

## Operation
- States: IDLE, COOLDOWN, WAIT_COND, LAUNCH, FLYING, SHOW.
- IDLE: playGame=1 → COOLDOWN; frame counter loaded with COOLDOWN_FRAMES.
- COOLDOWN: counter decrements on each startOfFrame. Counter reaching 0 → WAIT_COND.
- WAIT_COND: launch when all hold in one cycle:
  - alienMatrixYPosition > MIN_ALIEN_Y (signed compare);
  - MIN_LIMIT_X ≤ randX ≤ MAX_LIMIT_X;
  - randX ≠ previous limitX.
  - Then latch limitX←randX, go LAUNCH.
- LAUNCH: launch=1 for exactly this cycle. Clear seenAlive. Load counter with ALIVE_TIMEOUT_FRAMES. → FLYING.
- FLYING:
  - shipAlive=1 sets seenAlive.
  - bonusFireCollision=1 → award score, load HIT_SHOW_FRAMES, go SHOW.
  - Else seenAlive && !shipAlive (escaped) → COOLDOWN, counter←COOLDOWN_FRAMES.
  - Else !seenAlive: counter decrements per startOfFrame; reaching 0 → COOLDOWN (mover refused launch).
- SHOW: showScore=1; counter decrements per startOfFrame; reaching 0 → COOLDOWN.
- playGame=0 in any state → IDLE next cycle. This clears the counter, seenAlive and the shot counter, and drops showScore. limitX is retained.
- Shot counter: 4 bits. Increments on playerFire, wraps 14→0. It counts in every state except IDLE.
- Simultaneous events:
  - Collision and shipAlive falling in the same cycle count as a hit.
  - Collision outside FLYING is ignored.
  - playerFire in the same cycle as a hit is excluded from the table index; it is applied after.
  - startOfFrame while counter=0 has no further effect.

## Timing
- Reset values: launch 0, limitX MIN_LIMIT_X, scoreValid 0, scoreValue 0, showScore 0, state IDLE, counters 0.
- All outputs registered.
- launch asserts the cycle after WAIT_COND sees the conditions (LAUNCH state). limitX updates in that same cycle.
- scoreValid/scoreValue appear the cycle after bonusFireCollision is sampled. scoreValue holds until the next award.
- showScore rises together with scoreValid.
- Frame counts are exact: a counter loaded with N leaves its state on the Nth startOfFrame.
- Reset mid-flight: all outputs return to reset values immediately. No pulse is emitted.

## Configuration
- BONUS_SHOT_TABLE_EN defined: scoreValue = table[shotCnt]. The 15-entry table is 100,50,50,100,150,100,100,50,300,100,100,100,50,150,100.
- BONUS_SHOT_TABLE_EN undefined: scoreValue is fixed at 100. The shot counter and playerFire logic are removed, and playerFire is ignored.

## Structure
- Package bonus_ship_pkg holds:
  - state enum type (3 bits);
  - score table constant array;
  - width constants SCORE_W=9, LIMIT_W=10.
- Sub-module bonus_frame_timer: loadable 10-bit down-counter. Inputs load, loadValue, startOfFrame. Output done when at 0. One instance is shared by COOLDOWN, FLYING timeout and SHOW.

## Test plan
- Reset, then playGame=1 with COOLDOWN_FRAMES=4 → WAIT_COND after the 4th startOfFrame. With alienY=120 and randX=500, launch pulses 1 cycle later and limitX=500.
- In WAIT_COND: alienY=100 → no launch. randX=449 or 601 → no launch. randX equal to previous limitX → no launch.
- FLYING, shipAlive high, 8 playerFire pulses then collision → scoreValid 1 cycle later, scoreValue=300 (100 with macro off). showScore high for HIT_SHOW_FRAMES, then COOLDOWN.
- shipAlive rises then falls with no collision → COOLDOWN, no scoreValid. Collision and shipAlive falling in the same cycle → scoreValid asserted.
- shipAlive never rises after launch → COOLDOWN after 4 startOfFrames.
- playGame dropped during SHOW → IDLE next cycle, showScore=0. 16 shots with macro on → index wraps to 1 → scoreValue=50 on next hit.
